// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
//   wclass_e       : write class of the instruction in ID (none / ALU / load / MUL)
//   stall_reason_e : encoded cause of the ID-stage stall
//   lat()          : pending-cycle count loaded for a producer of a given class
package hazard_pkg;

    typedef enum logic [1:0] {
        WC_NONE = 2'd0,
        WC_ALU  = 2'd1,
        WC_LOAD = 2'd2,
        WC_MUL  = 2'd3
    } wclass_e;

    typedef enum logic [1:0] {
        SR_NONE   = 2'd0,
        SR_RAW_EX = 2'd1,
        SR_RAW_BR = 2'd2,
        SR_WAW    = 2'd3
    } stall_reason_e;

    // Latencies are passed in so that each scoreboard instance can use its own parameters.
    function automatic int lat(input wclass_e wc, input int alu_lat, input int load_lat,
                               input int mul_lat);
        int res;
        case (wc)
            WC_ALU:  res = alu_lat;
            WC_LOAD: res = load_lat;
            WC_MUL:  res = mul_lat;
            default: res = 0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hazard_pend_entry.sv
// One per-register countdown: cycles until the in-flight result can be forwarded.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : pipeline flush, forces the count to zero (highest priority)
//   load       : a new producer for this register issues; count <= load_val
//   load_val   : latency of that producer
//   pend       : current remaining count (0 = value available / nothing pending)
module hazard_pend_entry #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    output logic [PW-1:0] pend
);

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (clear) begin
            pend <= '0;
        end else if (load) begin
            pend <= load_val;
        end else if (pend != '0) begin
            pend <= pend - PW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard.
// Tracks per-register forwarding latency of in-flight producers and raises the
// ID stall for RAW (EX consumers and ID-resolved branches) and WAW hazards.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   id_valid        : ID holds a valid instruction
//   id_rs, id_rt    : source register indices; id_use_rs/id_use_rt qualify them
//   id_branch       : ID instruction is a branch resolved in ID (stricter threshold)
//   id_dest         : destination register index
//   id_wclass       : write class (0 none, 1 ALU, 2 load, 3 MUL)
//   kill            : flush; clears all pending state, suppresses stall and issue
//   stall           : hold PC and IF/ID, insert bubble into ID/EX
//   stall_reason    : 0 none, 1 RAW-EX, 2 RAW-branch, 3 WAW
//   stall_cnt       : saturating count of stalled cycles
//   stall_timeout   : sticky flag, MAX_STALL consecutive stall cycles seen
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int AW        = $clog2(NREG),
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int MUL_LAT   = 4,
    parameter int EX_THRESH = 2,
    parameter int BR_THRESH = 1,
    parameter int CW        = 32,
    parameter int MAX_STALL = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_branch,
    input  logic [AW-1:0] id_dest,
    input  logic [1:0]    id_wclass,
    input  logic          kill,
    output logic          stall,
    output logic [1:0]    stall_reason,
    output logic [CW-1:0] stall_cnt,
    output logic          stall_timeout
);

    localparam int PW  = $clog2(MUL_LAT + 1);
    localparam int RCW = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;

    localparam logic [PW-1:0]  EX_T   = PW'(EX_THRESH);
    localparam logic [PW-1:0]  BR_T   = PW'(BR_THRESH);
    localparam logic [RCW-1:0] RC_MAX = RCW'(MAX_STALL - 1);

    logic [PW-1:0]  pend [NREG];
    logic [PW-1:0]  thr;
    logic [PW-1:0]  lat_val;
    logic [RCW-1:0] rc;
    logic           active;
    logic           raw_rs;
    logic           raw_rt;
    logic           raw;
    logic           waw;
    logic           issue;
    wclass_e        wc;
    stall_reason_e  reason;

    assign wc = wclass_e'(id_wclass);

    // Register 0 is hard-wired zero, so it never has a pending producer.
    assign pend[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_pend
            hazard_pend_entry #(.PW(PW)) u_entry (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear    (kill),
                .load     (issue && (wc != WC_NONE) && (id_dest == AW'(r))),
                .load_val (lat_val),
                .pend     (pend[r])
            );
        end
    endgenerate

    // NOTE: every signal assigned here gets a default first, so no path through the
    // block leaves a value unassigned and no latch is inferred.
    always_comb begin
        thr     = id_branch ? BR_T : EX_T;
        lat_val = PW'(lat(wc, ALU_LAT, LOAD_LAT, MUL_LAT));
        active  = id_valid && !kill;
        // rs == rt collapses naturally into one hazard since both terms are ORed.
        raw_rs  = id_use_rs && (id_rs != '0) && (pend[id_rs] >= thr);
        raw_rt  = id_use_rt && (id_rt != '0) && (pend[id_rt] >= thr);
        raw     = active && (raw_rs || raw_rt);
        // A new writer must not complete before an older writer to the same register.
        waw     = active && (wc != WC_NONE) && (id_dest != '0) && (pend[id_dest] > lat_val);
        stall   = raw || waw;
        issue   = id_valid && !stall && !kill;

        reason = SR_NONE;
        if (raw && id_branch) begin
            reason = SR_RAW_BR;
        end else if (raw) begin
            reason = SR_RAW_EX;
        end else if (waw) begin
            reason = SR_WAW;
        end
    end

    assign stall_reason = reason;

    // Stall accounting and watchdog. rc counts consecutive stalled cycles already
    // completed; kill forces stall low, so it also clears rc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            rc            <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if (!stall) begin
                rc <= '0;
            end else if (rc == RC_MAX) begin
                stall_timeout <= 1'b1;
            end else begin
                rc <= rc + RCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed timing scenarios followed by
// random traffic, both compared against a cycle-level reference model of the
// scoreboard rules. A second instance (MAX_STALL=4, CW=3) exercises the watchdog
// and counter saturation with the same stimulus.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int MAX_A = 16;
    localparam int MAX_B = 4;
    localparam int CNT_B_MAX = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_branch;
    logic [AW-1:0] id_dest;
    logic [1:0]    id_wclass;
    logic          kill;

    logic          stall_a,  stall_b;
    logic [1:0]    reason_a, reason_b;
    logic [31:0]   cnt_a;
    logic [2:0]    cnt_b;
    logic          to_a,     to_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          pend_m [NREG];
    int unsigned mcnt_a;
    int          mcnt_b;
    int          run_len;
    logic        mto_a, mto_b;

    // Last sampled DUT values for directed checks
    logic        s_seen;
    logic [1:0]  r_seen;

    always #5 clk = ~clk;

    hazard_scoreboard dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_dest(id_dest), .id_wclass(id_wclass), .kill(kill),
        .stall(stall_a), .stall_reason(reason_a), .stall_cnt(cnt_a), .stall_timeout(to_a)
    );

    hazard_scoreboard #(.MAX_STALL(MAX_B), .CW(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_dest(id_dest), .id_wclass(id_wclass), .kill(kill),
        .stall(stall_b), .stall_reason(reason_b), .stall_cnt(cnt_b), .stall_timeout(to_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_m(input int wc);
        case (wc)
            1:       return 1;
            2:       return 2;
            3:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 0;
        mcnt_a  = 0;
        mcnt_b  = 0;
        run_len = 0;
        mto_a   = 1'b0;
        mto_b   = 1'b0;
    endtask

    // Expected stall and reason from the current model state and ID inputs.
    task automatic model_eval(output logic es, output logic [1:0] er);
        int  thr;
        bit  raw, waw;
        thr = id_branch ? 1 : 2;
        raw = (id_use_rs && id_rs != 0 && pend_m[id_rs] >= thr) ||
              (id_use_rt && id_rt != 0 && pend_m[id_rt] >= thr);
        waw = id_wclass != 0 && id_dest != 0 && pend_m[id_dest] > lat_m(int'(id_wclass));
        if (!id_valid || kill) begin
            raw = 0;
            waw = 0;
        end
        es = raw || waw;
        er = raw ? (id_branch ? 2'd2 : 2'd1) : (waw ? 2'd3 : 2'd0);
    endtask

    task automatic model_step(input logic es);
        bit issue;
        issue = id_valid && !es && !kill;
        for (int r = 1; r < NREG; r++) begin
            if (kill)                                            pend_m[r] = 0;
            else if (issue && id_wclass != 0 && int'(id_dest) == r) pend_m[r] = lat_m(int'(id_wclass));
            else if (pend_m[r] > 0)                              pend_m[r] = pend_m[r] - 1;
        end
        if (es) begin
            if (mcnt_a != 32'hFFFF_FFFF) mcnt_a = mcnt_a + 1;
            if (mcnt_b != CNT_B_MAX)     mcnt_b = mcnt_b + 1;
            run_len = run_len + 1;
            if (run_len >= MAX_A) mto_a = 1'b1;
            if (run_len >= MAX_B) mto_b = 1'b1;
        end else begin
            run_len = 0;
        end
    endtask

    // One clock cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic cycle(input logic v, input logic [AW-1:0] rs, input logic urs,
                         input logic [AW-1:0] rt, input logic urt, input logic br,
                         input logic [AW-1:0] dest, input logic [1:0] wc, input logic k);
        logic       es;
        logic [1:0] er;
        @(negedge clk);
        id_valid = v;  id_rs = rs;  id_use_rs = urs;  id_rt = rt;  id_use_rt = urt;
        id_branch = br; id_dest = dest; id_wclass = wc; kill = k;
        #1;
        model_eval(es, er);
        chk("stall_a",  stall_a,  es);
        chk("reason_a", reason_a, er);
        chk("stall_b",  stall_b,  es);
        chk("cnt_a",    cnt_a,    mcnt_a);
        chk("cnt_b",    cnt_b,    mcnt_b);
        chk("to_a",     to_a,     mto_a);
        chk("to_b",     to_b,     mto_b);
        s_seen = stall_a;
        r_seen = reason_a;
        @(posedge clk);
        model_step(es);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic produce(input logic [AW-1:0] dest, input logic [1:0] wc);
        cycle(1, 0, 0, 0, 0, 0, dest, wc, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_dest = 0; id_wclass = 0; kill = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",  stall_a,  0);
        chk("rst_reason", reason_a, 0);
        chk("rst_cnt",    cnt_a,    0);
        chk("rst_to",     to_a,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU r3, then EX consumer of r3: forwarded, no stall
        produce(3, 2'd1);
        cycle(1, 3, 1, 0, 0, 0, 8, 2'd1, 0);
        chk("alu_ex_nostall", s_seen, 0);
        idle(5);

        // load r5, EX consumer on rt: one stall cycle, RAW-EX
        produce(5, 2'd2);
        cycle(1, 0, 0, 5, 1, 0, 9, 2'd1, 0);
        chk("ld_ex_stall", s_seen, 1);
        chk("ld_ex_reason", r_seen, 1);
        cycle(1, 0, 0, 5, 1, 0, 9, 2'd1, 0);
        chk("ld_ex_issue", s_seen, 0);
        chk("ld_ex_cnt", cnt_a, 1);
        idle(5);

        // load r5, branch on rs: two stall cycles, RAW-branch; rs==rt counts once
        produce(5, 2'd2);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 5, 1, 5, 1, 1, 0, 2'd0, 0);
            chk("ld_br_stall", s_seen, 1);
            chk("ld_br_reason", r_seen, 2);
        end
        cycle(1, 5, 1, 5, 1, 1, 0, 2'd0, 0);
        chk("ld_br_issue", s_seen, 0);
        idle(6);

        // mul r7, ALU write r7: three WAW stall cycles, then issue leaves pend[7]=1
        produce(7, 2'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 7, 2'd1, 0);
            chk("waw_stall", s_seen, 1);
            chk("waw_reason", r_seen, 3);
        end
        cycle(1, 0, 0, 0, 0, 0, 7, 2'd1, 0);
        chk("waw_issue", s_seen, 0);
        cycle(1, 7, 1, 0, 0, 1, 0, 2'd0, 0);
        chk("waw_pend1_br", s_seen, 1);
        cycle(1, 7, 1, 0, 0, 1, 0, 2'd0, 0);
        chk("waw_pend0_br", s_seen, 0);
        idle(6);

        // mul r7 then kill with a hazarding consumer: kill wins, state cleared
        produce(7, 2'd3);
        cycle(1, 7, 1, 0, 0, 1, 0, 2'd0, 1);
        chk("kill_nostall", s_seen, 0);
        cycle(1, 7, 1, 0, 0, 1, 0, 2'd0, 0);
        chk("post_kill_br", s_seen, 0);
        idle(2);

        // Writes to r0 never create pending state
        produce(0, 2'd3);
        cycle(1, 0, 1, 0, 1, 1, 0, 2'd3, 0);
        chk("r0_nostall", s_seen, 0);
        idle(2);

        // mul r2, branch on r2: 4 stalls trip the MAX_STALL=4 watchdog only
        produce(2, 2'd3);
        for (int i = 0; i < 4; i++) cycle(1, 2, 1, 0, 0, 1, 0, 2'd0, 0);
        cycle(1, 2, 1, 0, 0, 1, 0, 2'd0, 0);
        chk("wd_b_set", to_b, 1);
        chk("wd_a_clear", to_a, 0);
        idle(3);
        chk("wd_b_sticky", to_b, 1);
        chk("cnt_a_total", cnt_a, 11);
        chk("cnt_b_sat", cnt_b, 7);

        // Asynchronous reset in the middle of a stall
        produce(2, 2'd3);
        cycle(1, 2, 1, 0, 0, 1, 0, 2'd0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_a, 0);
        chk("arst_cnt_a", cnt_a, 0);
        chk("arst_cnt_b", cnt_b, 0);
        chk("arst_to_b", to_b, 0);
        model_reset();
        @(negedge clk);
        id_valid = 0;
        rst_n = 1'b1;

        // Random traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(9, 0) != 0,
                  AW'($urandom_range(7, 0)), 1'($urandom),
                  AW'($urandom_range(7, 0)), 1'($urandom),
                  $urandom_range(3, 0) == 0,
                  AW'($urandom_range(7, 0)), 2'($urandom),
                  $urandom_range(40, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational load-use/branch hazard detector.
- Tracks, per architectural register, the cycles remaining until an in-flight result can be forwarded. Producers are ALU ops, loads and multi-cycle MUL ops.
- Generates the ID-stage stall for RAW and WAW hazards, with separate thresholds for EX-stage consumers and ID-resolved branches.
- Adds stall accounting and a stall watchdog; sits beside the ID stage and drives the PC/IF-ID hold and ID/EX bubble.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero and is never pending.
- AW, $clog2(NREG), register index width.
- ALU_LAT, 1, pending value loaded for an ALU producer.
- LOAD_LAT, 2, pending value loaded for a load producer.
- MUL_LAT, 4, pending value loaded for a MUL producer.
- EX_THRESH, 2, a non-branch consumer stalls while pend[src] >= EX_THRESH.
- BR_THRESH, 1, a branch consumer (operands read in ID) stalls while pend[src] >= BR_THRESH.
- CW, 32, width of the stall cycle counter.
- MAX_STALL, 16, consecutive stall cycles that trip the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  AW  source 1 index
- id_rt  in  AW  source 2 index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_branch  in  1  ID instruction is a branch resolved in ID
- id_dest  in  AW  destination index
- id_wclass  in  2  write class: 0 none, 1 ALU, 2 LOAD, 3 MUL
- kill  in  1  pipeline flush (exception); clears all pending state
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- stall_reason  out  2  0 none, 1 RAW-EX, 2 RAW-branch, 3 WAW
- stall_cnt  out  CW  total stalled cycles, saturating
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- State: pend[1..NREG-1], each PW=$clog2(MUL_LAT+1) bits; run counter rc; stall_cnt; stall_timeout.
- Reset (async, rst_n=0): all pend=0, rc=0, stall_cnt=0, stall_timeout=0. stall and stall_reason are combinational and evaluate to 0 while all pend=0.
- lat(class): ALU_LAT, LOAD_LAT or MUL_LAT; class 0 means no write.
- thr: BR_THRESH if id_branch, else EX_THRESH.
- Combinational stall, all terms gated by id_valid and !kill; src index 0 never hazards:
  - RAW: (id_use_rs && pend[id_rs] >= thr) or (id_use_rt && pend[id_rt] >= thr).
  - WAW: id_wclass != 0 && id_dest != 0 && pend[id_dest] > lat(id_wclass).
- stall_reason priority: RAW-branch (id_branch set), then RAW-EX, then WAW. Equals 0 when stall=0.
- issue = id_valid && !stall && !kill.
- Per clock edge, for each r != 0:
  - if kill: pend[r] <= 0;
  - else if issue && id_wclass != 0 && id_dest == r: pend[r] <= lat(id_wclass);
  - else if pend[r] != 0: pend[r] <= pend[r] - 1.
- Countdown continues while stalled; producers already past ID keep advancing.
- Issue to dest 0 changes no state.
- Timing reference (defaults): ALU producer issued at t; an EX consumer at t+1 issues with no stall; a branch at t+1 stalls 1 cycle. Load producer: EX consumer stalls 1 cycle, branch stalls 2. MUL producer: EX consumer stalls 3 cycles, branch stalls 4.
- Same register on rs and rt is one hazard.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.
- rc increments while stall=1 and clears when stall=0 or on kill. When rc reaches MAX_STALL-1 with stall still 1, stall_timeout <= 1 and remains set until reset.
- kill and stall in the same cycle: kill wins, stall=0, and nothing issues.

Decomposition:
- Shared package hazard_pkg: wclass_e (NONE/ALU/LOAD/MUL), stall_reason_e, and function lat().
- Sub-module hazard_pend_entry: one countdown register with load/decrement/clear, instantiated NREG-1 times by generate.
- Top level holds the compare, priority, counter and watchdog logic.

Test Plan:
- ALU write r3 issued; next cycle add with rs=3, thr=2 -> stall=0, and the add issues.
- lw r5 issued; next cycle add reads rt=5 -> stall=1 for exactly 1 cycle, reason=1; stall_cnt 0->1.
- lw r5 then beq reading rs=5 -> stall=1 for 2 cycles, reason=2; a third beq cycle issues.
- mul r7 issued; next cycle ALU write r7 with no read -> WAW stall (pend 4>1, then 3>1, then 2>1) for 3 cycles, reason=3; then issues and pend[7]=1.
- mul r7, then kill=1 in the next cycle -> all pend=0; a following read of r7 gives no stall.
- MAX_STALL=4: hold a branch on pending r2 with producer repeatedly re-issued via forced pend -> stall_timeout=1 after 4 stall cycles and stays set; rst_n low mid-stall clears everything asynchronously.
